mem_rd_arbiter: RTL and testbench

MEM_RD_ARBITER -- requirements
Module: mem_rd_arbiter

---
 rtl/mem_rd_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_rd_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_rd_arbiter.sv
// Read-burst arbiter: shares one memory read port between the I-cache and D-cache.
// Only one burst is in flight at a time. Ties are broken round-robin on the last requester served.
module mem_rd_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  icache_rd_req_valid,
  input  logic [ADDR_WIDTH-1:0] icache_rd_req_addr,
  output logic                  icache_rd_req_ready,
  output logic                  icache_rd_rsp_valid,
  output logic [DATA_WIDTH-1:0] icache_rd_rsp_data,
  output logic                  icache_rd_rsp_last,
  input  logic                  icache_rd_rsp_ready,

  input  logic                  dcache_rd_req_valid,
  input  logic [ADDR_WIDTH-1:0] dcache_rd_req_addr,
  output logic                  dcache_rd_req_ready,
  output logic                  dcache_rd_rsp_valid,
  output logic [DATA_WIDTH-1:0] dcache_rd_rsp_data,
  output logic                  dcache_rd_rsp_last,
  input  logic                  dcache_rd_rsp_ready,

  output logic                  to_mem_rd_req_valid,
  output logic [ADDR_WIDTH-1:0] to_mem_rd_req_addr,
  input  logic                  from_mem_rd_req_ready,
  input  logic                  from_mem_rd_rsp_valid,
  input  logic [DATA_WIDTH-1:0] from_mem_rd_rsp_data,
  input  logic                  from_mem_rd_rsp_last,
  output logic                  to_mem_rd_rsp_ready,

  output logic [1:0]            arb_grant
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StReq  = 2'd1;
  localparam logic [1:0] StRsp  = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [1:0]            grant_q, grant_d;
  logic                  last_d_q, last_d_d;  // 1: D-cache was served last
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;

  logic in_req, in_rsp;
  logic gnt_i, gnt_d;
  logic gnt_rsp_ready;
  logic burst_done;

  assign in_req = (state_q == StReq);
  assign in_rsp = (state_q == StRsp);
  assign gnt_i  = grant_q[0];
  assign gnt_d  = grant_q[1];

  assign gnt_rsp_ready = (gnt_i & icache_rd_rsp_ready) | (gnt_d & dcache_rd_rsp_ready);
  assign burst_done    = in_rsp & from_mem_rd_rsp_valid & gnt_rsp_ready & from_mem_rd_rsp_last;

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d_d = last_d_q;
    addr_d   = addr_q;
    unique case (state_q)
      StIdle: begin
        // On a tie the I-cache wins only if the D-cache was served last.
        if (icache_rd_req_valid && (!dcache_rd_req_valid || last_d_q)) begin
          grant_d = 2'b01;
          addr_d  = icache_rd_req_addr;
          state_d = StReq;
        end else if (dcache_rd_req_valid) begin
          grant_d = 2'b10;
          addr_d  = dcache_rd_req_addr;
          state_d = StReq;
        end
      end
      StReq: begin
        if (from_mem_rd_req_ready) begin
          state_d = StRsp;
        end
      end
      StRsp: begin
        if (burst_done) begin
          state_d  = StIdle;
          grant_d  = 2'b00;
          last_d_d = gnt_d;
        end
      end
      default: begin
        state_d = StIdle;
        grant_d = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      grant_q  <= 2'b00;
      last_d_q <= 1'b1;
      addr_q   <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_d_q <= last_d_d;
      addr_q   <= addr_d;
    end
  end

  // Memory request side depends only on registered state.
  assign to_mem_rd_req_valid = in_req;
  assign to_mem_rd_req_addr  = addr_q;
  assign icache_rd_req_ready = in_req & gnt_i & from_mem_rd_req_ready;
  assign dcache_rd_req_ready = in_req & gnt_d & from_mem_rd_req_ready;

  // Response beats pass straight through to the owner; the other side sees zeros.
  assign to_mem_rd_rsp_ready = in_rsp & gnt_rsp_ready;
  assign icache_rd_rsp_valid = in_rsp & gnt_i & from_mem_rd_rsp_valid;
  assign icache_rd_rsp_last  = in_rsp & gnt_i & from_mem_rd_rsp_last;
  assign icache_rd_rsp_data  = (in_rsp & gnt_i) ? from_mem_rd_rsp_data : '0;
  assign dcache_rd_rsp_valid = in_rsp & gnt_d & from_mem_rd_rsp_valid;
  assign dcache_rd_rsp_last  = in_rsp & gnt_d & from_mem_rd_rsp_last;
  assign dcache_rd_rsp_data  = (in_rsp & gnt_d) ? from_mem_rd_rsp_data : '0;

  assign arb_grant = grant_q;

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// Scoreboard bench for mem_rd_arbiter: a memory model, two requester drivers and a
// per-cycle monitor comparing routed beats against queued expectations.
module tb_mem_rd_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          icache_rd_req_valid, icache_rd_req_ready;
  logic [AW-1:0] icache_rd_req_addr;
  logic          icache_rd_rsp_valid, icache_rd_rsp_last, icache_rd_rsp_ready;
  logic [DW-1:0] icache_rd_rsp_data;
  logic          dcache_rd_req_valid, dcache_rd_req_ready;
  logic [AW-1:0] dcache_rd_req_addr;
  logic          dcache_rd_rsp_valid, dcache_rd_rsp_last, dcache_rd_rsp_ready;
  logic [DW-1:0] dcache_rd_rsp_data;
  logic          to_mem_rd_req_valid, from_mem_rd_req_ready;
  logic [AW-1:0] to_mem_rd_req_addr;
  logic          from_mem_rd_rsp_valid, from_mem_rd_rsp_last, to_mem_rd_rsp_ready;
  logic [DW-1:0] from_mem_rd_rsp_data;
  logic [1:0]    arb_grant;

  mem_rd_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .icache_rd_req_valid   (icache_rd_req_valid),
    .icache_rd_req_addr    (icache_rd_req_addr),
    .icache_rd_req_ready   (icache_rd_req_ready),
    .icache_rd_rsp_valid   (icache_rd_rsp_valid),
    .icache_rd_rsp_data    (icache_rd_rsp_data),
    .icache_rd_rsp_last    (icache_rd_rsp_last),
    .icache_rd_rsp_ready   (icache_rd_rsp_ready),
    .dcache_rd_req_valid   (dcache_rd_req_valid),
    .dcache_rd_req_addr    (dcache_rd_req_addr),
    .dcache_rd_req_ready   (dcache_rd_req_ready),
    .dcache_rd_rsp_valid   (dcache_rd_rsp_valid),
    .dcache_rd_rsp_data    (dcache_rd_rsp_data),
    .dcache_rd_rsp_last    (dcache_rd_rsp_last),
    .dcache_rd_rsp_ready   (dcache_rd_rsp_ready),
    .to_mem_rd_req_valid   (to_mem_rd_req_valid),
    .to_mem_rd_req_addr    (to_mem_rd_req_addr),
    .from_mem_rd_req_ready (from_mem_rd_req_ready),
    .from_mem_rd_rsp_valid (from_mem_rd_rsp_valid),
    .from_mem_rd_rsp_data  (from_mem_rd_rsp_data),
    .from_mem_rd_rsp_last  (from_mem_rd_rsp_last),
    .to_mem_rd_rsp_ready   (to_mem_rd_rsp_ready),
    .arb_grant             (arb_grant)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic who; logic [AW-1:0] addr; } req_t;  // who: 0 I-cache, 1 D-cache
  typedef struct packed { logic who; logic [DW-1:0] data; logic last; } beat_t;

  req_t          exp_req_q[$];
  beat_t         exp_beat_q[$];
  logic [AW-1:0] i_addr_q[$];
  logic [AW-1:0] d_addr_q[$];

  int   n_checks = 0;
  int   n_fail = 0;
  int   burst_no = 0;
  int   mem_beat = 0;
  int   stall_cfg = 0;
  int   stall_left = 0;
  int   beats_done = 0;
  int   req_wait = 0;
  logic mem_active = 1'b0;
  logic owner = 1'b0;
  logic rsp_toggle = 1'b0;
  logic rsp_rdy = 1'b1;
  logic drop_in_req = 1'b0;
  logic idle_chk = 1'b0;
  logic prev_pending = 1'b0;
  logic req_hs = 1'b0, rsp_hs = 1'b0, i_hs = 1'b0, d_hs = 1'b0, req_seen = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] beat_data(input int bn, input int k);
    return {8'(bn), 16'h0, 8'((k + 1) * 17)};
  endfunction

  task automatic expect_req(input logic who, input logic [AW-1:0] addr);
    exp_req_q.push_back(req_t'{who: who, addr: addr});
  endtask

  task automatic check_beat(input logic who, input logic [DW-1:0] data, input logic last);
    beat_t b;
    if (exp_beat_q.size() == 0) begin
      check_eq("unexpected_beat", 64'(1), 64'(0));
    end else begin
      b = exp_beat_q.pop_front();
      check_eq("beat_dest", 64'(who), 64'(b.who));
      check_eq("beat_data", 64'(data), 64'(b.data));
      check_eq("beat_last", 64'(last), 64'(b.last));
      beats_done++;
      if (b.last) idle_chk = 1'b1;
    end
  endtask

  task automatic sample_and_check();
    req_t r;
    logic exp_iv, exp_dv;
    req_hs   = to_mem_rd_req_valid && from_mem_rd_req_ready;
    rsp_hs   = from_mem_rd_rsp_valid && to_mem_rd_rsp_ready;
    i_hs     = icache_rd_req_valid && icache_rd_req_ready;
    d_hs     = dcache_rd_req_valid && dcache_rd_req_ready;
    req_seen = to_mem_rd_req_valid;
    if (idle_chk) begin
      check_eq("grant_idle", 64'(arb_grant), 64'(0));
      check_eq("idle_gap", 64'(to_mem_rd_req_valid), 64'(0));
      idle_chk = 1'b0;
    end
    if (prev_pending) check_eq("req_valid_held", 64'(to_mem_rd_req_valid), 64'(1));
    prev_pending = to_mem_rd_req_valid && !req_hs;
    if (to_mem_rd_req_valid) begin
      if (!from_mem_rd_req_ready) req_wait++;
      if (exp_req_q.size() == 0) begin
        check_eq("unexpected_req", 64'(1), 64'(0));
      end else begin
        r = exp_req_q[0];
        check_eq("mem_addr", 64'(to_mem_rd_req_addr), 64'(r.addr));
        check_eq("arb_grant", 64'(arb_grant), 64'(r.who ? 2'b10 : 2'b01));
        check_eq("i_req_ready", 64'(icache_rd_req_ready), 64'(!r.who && from_mem_rd_req_ready));
        check_eq("d_req_ready", 64'(dcache_rd_req_ready), 64'(r.who && from_mem_rd_req_ready));
        if (req_hs) begin
          void'(exp_req_q.pop_front());
          owner = r.who;
          for (int k = 0; k < 8; k++)
            exp_beat_q.push_back(beat_t'{who: r.who, data: beat_data(burst_no, k), last: (k == 7)});
        end
      end
    end else begin
      check_eq("ready_no_req", 64'({icache_rd_req_ready, dcache_rd_req_ready}), 64'(0));
    end
    exp_iv = mem_active && !owner && from_mem_rd_rsp_valid;
    exp_dv = mem_active && owner && from_mem_rd_rsp_valid;
    check_eq("i_rsp_valid", 64'(icache_rd_rsp_valid), 64'(exp_iv));
    check_eq("d_rsp_valid", 64'(dcache_rd_rsp_valid), 64'(exp_dv));
    if (mem_active) begin
      check_eq("rsp_ready_mirror", 64'(to_mem_rd_rsp_ready),
               64'(owner ? dcache_rd_rsp_ready : icache_rd_rsp_ready));
      check_eq("nongrant_data", 64'(owner ? icache_rd_rsp_data : dcache_rd_rsp_data), 64'(0));
    end else begin
      check_eq("rsp_ready_idle", 64'(to_mem_rd_rsp_ready), 64'(0));
    end
    if (icache_rd_rsp_valid && icache_rd_rsp_ready)
      check_beat(1'b0, icache_rd_rsp_data, icache_rd_rsp_last);
    if (dcache_rd_rsp_valid && dcache_rd_rsp_ready)
      check_beat(1'b1, dcache_rd_rsp_data, dcache_rd_rsp_last);
  endtask

  task automatic present_beat();
    from_mem_rd_rsp_valid = 1'b1;
    from_mem_rd_rsp_data  = beat_data(burst_no, mem_beat);
    from_mem_rd_rsp_last  = (mem_beat == 7);
  endtask

  task automatic drive_env();
    if (!rst) begin
      from_mem_rd_req_ready = 1'b0;
      from_mem_rd_rsp_valid = 1'b0;
      from_mem_rd_rsp_data  = '0;
      from_mem_rd_rsp_last  = 1'b0;
      icache_rd_req_valid   = 1'b0;
      icache_rd_req_addr    = '0;
      dcache_rd_req_valid   = 1'b0;
      dcache_rd_req_addr    = '0;
      i_addr_q.delete();
      d_addr_q.delete();
      stall_left = stall_cfg;
      mem_active = 1'b0;
      return;
    end
    if (req_hs) begin
      from_mem_rd_req_ready = 1'b0;
      mem_active = 1'b1;
      mem_beat   = 0;
      stall_left = stall_cfg;
      present_beat();
    end else if (!mem_active && req_seen) begin
      if (stall_left > 0) stall_left--;
      else from_mem_rd_req_ready = 1'b1;
    end else if (rsp_hs) begin
      if (mem_beat == 7) begin
        mem_active = 1'b0;
        from_mem_rd_rsp_valid = 1'b0;
        from_mem_rd_rsp_data  = '0;
        from_mem_rd_rsp_last  = 1'b0;
        burst_no++;
      end else begin
        mem_beat++;
        present_beat();
      end
    end
    if (i_hs && i_addr_q.size() > 0) void'(i_addr_q.pop_front());
    if (d_hs && d_addr_q.size() > 0) void'(d_addr_q.pop_front());
    // Requester abandons its request once the arbiter has taken it to memory.
    if (drop_in_req && req_seen && dcache_rd_req_valid && d_addr_q.size() > 0)
      void'(d_addr_q.pop_front());
    icache_rd_req_valid = (i_addr_q.size() > 0);
    icache_rd_req_addr  = (i_addr_q.size() > 0) ? i_addr_q[0] : '0;
    dcache_rd_req_valid = (d_addr_q.size() > 0);
    dcache_rd_req_addr  = (d_addr_q.size() > 0) ? d_addr_q[0] : '0;
    rsp_rdy = rsp_toggle ? !rsp_rdy : 1'b1;
    icache_rd_rsp_ready = rsp_rdy;
    dcache_rd_rsp_ready = rsp_rdy;
  endtask

  initial begin : env
    from_mem_rd_req_ready = 1'b0;
    from_mem_rd_rsp_valid = 1'b0;
    from_mem_rd_rsp_data  = '0;
    from_mem_rd_rsp_last  = 1'b0;
    icache_rd_req_valid   = 1'b0;
    icache_rd_req_addr    = '0;
    dcache_rd_req_valid   = 1'b0;
    dcache_rd_req_addr    = '0;
    icache_rd_rsp_ready   = 1'b1;
    dcache_rd_rsp_ready   = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst) begin
        mem_active = 1'b0;
        exp_beat_q.delete();
        idle_chk = 1'b0;
        prev_pending = 1'b0;
        {req_hs, rsp_hs, i_hs, d_hs, req_seen} = '0;
      end else begin
        sample_and_check();
      end
      @(posedge clk);
      #1;
      drive_env();
    end
  end

  task automatic check_zero(input string tag);
    check_eq({tag, "_i_ready"}, 64'(icache_rd_req_ready), 64'(0));
    check_eq({tag, "_i_rsp"}, 64'({icache_rd_rsp_valid, icache_rd_rsp_last, icache_rd_rsp_data}),
             64'(0));
    check_eq({tag, "_d_ready"}, 64'(dcache_rd_req_ready), 64'(0));
    check_eq({tag, "_d_rsp"}, 64'({dcache_rd_rsp_valid, dcache_rd_rsp_last, dcache_rd_rsp_data}),
             64'(0));
    check_eq({tag, "_mem_req"}, 64'({to_mem_rd_req_valid, to_mem_rd_req_addr}), 64'(0));
    check_eq({tag, "_mem_rsp_ready"}, 64'(to_mem_rd_rsp_ready), 64'(0));
    check_eq({tag, "_grant"}, 64'(arb_grant), 64'(0));
  endtask

  task automatic wait_done(input string tag, input int max_cyc);
    int n = 0;
    while ((exp_req_q.size() != 0 || exp_beat_q.size() != 0 || mem_active ||
            i_addr_q.size() != 0 || d_addr_q.size() != 0) && n < max_cyc) begin
      @(posedge clk);
      #3;
      n++;
    end
    check_eq({tag, "_done"}, 64'(n < max_cyc), 64'(1));
    exp_req_q.delete();
    repeat (2) @(posedge clk);
    #3;
  endtask

  initial begin : main
    int base;
    int n;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    check_zero("reset");
    rst = 1'b1;
    @(posedge clk);
    #3;

    // I-cache alone.
    expect_req(1'b0, 32'h0000_1000);
    i_addr_q.push_back(32'h0000_1000);
    wait_done("icache_only", 300);

    // Fresh reset, then a tie; I-cache re-requests so the second tie goes to the D-cache.
    rst = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b1;
    @(posedge clk);
    #3;
    expect_req(1'b0, 32'h0000_0100);
    expect_req(1'b1, 32'h0000_0200);
    expect_req(1'b0, 32'h0000_0300);
    i_addr_q.push_back(32'h0000_0100);
    i_addr_q.push_back(32'h0000_0300);
    d_addr_q.push_back(32'h0000_0200);
    wait_done("tie", 600);

    // Memory stalls acceptance; the D-cache withdraws its valid meanwhile.
    stall_cfg   = 5;
    stall_left  = 5;
    drop_in_req = 1'b1;
    req_wait    = 0;
    expect_req(1'b1, 32'h0000_2000);
    d_addr_q.push_back(32'h0000_2000);
    wait_done("stall", 300);
    check_eq("stall_cycles", 64'(req_wait), 64'(6));
    stall_cfg   = 0;
    stall_left  = 0;
    drop_in_req = 1'b0;

    // Owner's rsp_ready toggling every cycle.
    rsp_toggle = 1'b1;
    expect_req(1'b0, 32'h0000_3000);
    i_addr_q.push_back(32'h0000_3000);
    wait_done("toggle", 400);
    rsp_toggle = 1'b0;

    // Reset in the middle of a D-cache burst.
    base = beats_done;
    n = 0;
    expect_req(1'b1, 32'h0000_4000);
    d_addr_q.push_back(32'h0000_4000);
    while (beats_done < base + 4 && n < 200) begin
      @(posedge clk);
      #3;
      n++;
    end
    check_eq("rst_beat_wait", 64'(n < 200), 64'(1));
    rst = 1'b0;
    #1;
    check_zero("rst_mid");
    repeat (2) @(posedge clk);
    #3;
    exp_req_q.delete();
    rst = 1'b1;
    @(posedge clk);
    #3;
    check_eq("post_rst_idle", 64'({to_mem_rd_req_valid, arb_grant}), 64'(0));
    expect_req(1'b0, 32'h0000_5000);
    i_addr_q.push_back(32'h0000_5000);
    wait_done("post_rst", 300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
